aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encryption round sequencer. Accepts one 128-bit block per
//  handshake, performs the initial AddRoundKey, then drives an external
//  combinational round datapath once per round. The datapath is
//  SubBytes->ShiftRows->MixColumns->AddRoundKey, with MixColumns skipped when
//  dp_final=1. Round keys come from the key schedule via rk_req/rk_valid.
//  Sits between the host block interface and the round datapath/key expansion.
// PARAMETERS
//  NR       10  number of rounds (10/12/14 for AES-128/192/256)
//  RIDX_W   4   width of round index; must hold NR
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  abort      in   1    synchronous flush of the in-flight block
//  in_valid   in   1    input block valid
//  in_ready   out  1    ready to accept a block (=1 only in IDLE)
//  in_block   in   128  plaintext block
//  out_valid  out  1    ciphertext valid
//  out_ready  in   1    consumer ready
//  out_block  out  128  ciphertext, equal to state register
//  rk_req     out  1    round key request
//  rk_idx     out  RIDX_W requested round-key index, 0..NR
//  rk_valid   in   1    rk holds key rk_idx; may assert same cycle as rk_req
//  rk         in   128  round key
//  dp_state   out  128  state fed to the round datapath (= state register)
//  dp_key     out  128  = rk
//  dp_final   out  1    1 iff FSM=ROUND and round==NR
//  dp_result  in   128  round datapath output, combinational from dp_*
//  busy       out  1    FSM != IDLE
// BEHAVIOUR
//  FSM: IDLE, KEY0, ROUND, DONE; registers st[127:0], round[RIDX_W-1:0].
//  Reset (async, any time): FSM=IDLE, st=0, round=0.
//   Output values during reset: in_ready=1, out_valid=0, rk_req=0,
//   rk_idx=0, busy=0, dp_final=0, out_block=0.
//   No handshake completes while rst=1.
//  IDLE: in_valid&in_ready at an edge -> st<=in_block, round<=0, FSM=KEY0.
//   rk_valid is ignored.
//  KEY0: rk_req=1, rk_idx=0.
//   On an rk_valid edge: st<=st^rk, round<=1, FSM=ROUND.
//  ROUND: rk_req=1, rk_idx=round.
//   On an rk_valid edge: st<=dp_result.
//   If round==NR -> FSM=DONE, else round<=round+1.
//  Without rk_valid, all state holds; rk_idx is stable until rk_valid is seen.
//  DONE: out_valid=1, out_block=st, stable until out_ready.
//   On out_ready at an edge -> FSM=IDLE, st and round keep their values.
//   No same-cycle accept; the next block is accepted earliest one edge later.
//  Latency with rk_valid tied high: out_valid rises after edge NR+1,
//   counting the accept edge as edge 0 (11 edges for NR=10).
//   Each rk wait cycle adds one edge.
//  abort=1 at an edge, in any state: FSM=IDLE, round=0, st unchanged.
//   Takes priority over every other transition, including a DONE handoff.
//   Any pending output is dropped.
//  round never exceeds NR. rk_idx is 0 in IDLE/DONE; rk_req=0 in IDLE/DONE.
// TESTING
//  1 FIPS-197 C.1 vector.
//    Stimulus: in 00112233445566778899aabbccddeeff, key 000102..0f, NR=10.
//    Bench supplies the key schedule (rk_valid tied 1) and a golden datapath.
//    Response: out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid after edge 11.
//  2 Same vector, rk_valid delayed 3 cycles after each rk_req.
//    Response: same result at edge 44; rk_idx steps 0..10 with no skip or repeat.
//  3 Hold out_ready=0 for 5 cycles in DONE.
//    Response: out_valid=1, out_block constant, in_ready=0.
//    Then out_ready=1: IDLE next edge, in_ready=1.
//  4 abort with round=5.
//    Response: next edge IDLE, rk_req=0, no out_valid.
//    A following block gives the correct ciphertext.
//  5 rst pulsed between edges while in ROUND.
//    Response: outputs take reset values immediately.
//    After release, vector 1 passes.
//  6 Pulse rk_valid while IDLE; check dp_final.
//    Response: no state change in IDLE; dp_final=1 only while rk_idx==10.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Block, round-key and round-datapath signals of the AES round sequencer.
// The master side is the host, the key schedule and the datapath. The slave side is the sequencer.
interface aes_round_ctrl_if #(parameter int RIDX_W = 4);
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_block;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
  logic              rk_req;
  logic [RIDX_W-1:0] rk_idx;
  logic              rk_valid;
  logic [127:0]      rk;
  logic [127:0]      dp_state;
  logic [127:0]      dp_key;
  logic              dp_final;
  logic [127:0]      dp_result;
  logic              busy;

  modport master (
    output abort, in_valid, in_block, out_ready, rk_valid, rk, dp_result,
    input  in_ready, out_valid, out_block, rk_req, rk_idx, dp_state, dp_key,
           dp_final, busy
  );

  modport slave (
    input  abort, in_valid, in_block, out_ready, rk_valid, rk, dp_result,
    output in_ready, out_valid, out_block, rk_req, rk_idx, dp_state, dp_key,
           dp_final, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer. It applies the initial AddRoundKey, then steps an
// external round datapath once per round, pacing each step on round-key availability.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  aes_round_ctrl_if.slave io
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEY0  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [RIDX_W-1:0] NR_L = RIDX_W'(NR);

  logic [1:0]        state_q, state_d;
  logic [127:0]      st_q, st_d;
  logic [RIDX_W-1:0] round_q, round_d;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    round_d = round_q;
    // abort overrides everything, including a DONE handoff; st is kept as-is
    if (io.abort) begin
      state_d = S_IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (io.in_valid) begin
          st_d    = io.in_block;
          round_d = '0;
          state_d = S_KEY0;
        end
        S_KEY0: if (io.rk_valid) begin
          st_d    = st_q ^ io.rk;
          round_d = RIDX_W'(1);
          state_d = S_ROUND;
        end
        S_ROUND: if (io.rk_valid) begin
          st_d = io.dp_result;
          if (round_q == NR_L) state_d = S_DONE;
          else                 round_d = round_q + 1'b1;
        end
        S_DONE: if (io.out_ready) state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      round_q <= round_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_block = st_q;
  assign io.rk_req    = (state_q == S_KEY0) || (state_q == S_ROUND);
  // In KEY0, round_q is 0, so only ROUND exposes the counter.
  assign io.rk_idx    = (state_q == S_ROUND) ? round_q : '0;
  assign io.dp_state  = st_q;
  assign io.dp_key    = io.rk;
  assign io.dp_final  = (state_q == S_ROUND) && (round_q == NR_L);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. It supplies the AES-128 key schedule and a golden round
// datapath, and checks the outputs every cycle against an AES reference model.
module tb_aes_round_ctrl;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  aes_round_ctrl_if #(.RIDX_W(4)) bus ();

  aes_round_ctrl #(.NR(NR), .RIDX_W(4)) dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] b = x;
    logic [7:0] e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  logic [127:0] rkeys [0:NR];

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rkeys[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rkeys[r], r == NR);
    return s;
  endfunction

  // ---------------- key schedule / datapath / rk_valid pacing ----------------
  logic       dly_mode = 1'b0;
  logic       rk_force = 1'b0;
  logic [2:0] wcnt = 3'd0;

  assign bus.rk        = (bus.rk_idx <= 4'(NR)) ? rkeys[bus.rk_idx] : '0;
  assign bus.dp_result = aes_round(bus.dp_state, bus.dp_key, bus.dp_final);
  assign bus.rk_valid  = rk_force | (dly_mode ? (bus.rk_req && wcnt == 3'd3) : 1'b1);

  always @(posedge clk) wcnt <= (!bus.rk_req || bus.rk_valid) ? 3'd0 : wcnt + 3'd1;

  // ---------------- checking ----------------
  logic [127:0] exp_ct;
  int           seq = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Per-cycle rules, evaluated at the falling edge
  task automatic monitor();
    if (rst) return;
    chk("in_ready_vs_busy", bus.in_ready, !bus.busy);
    chk("rk_req_phase", bus.rk_req, bus.busy && !bus.out_valid);
    chk("dp_final", bus.dp_final, bus.rk_req && (bus.rk_idx == 4'(NR)));
    if (!bus.rk_req) chk("rk_idx_idle", bus.rk_idx, 0);
    chk("dp_state", bus.dp_state, bus.out_block);
    chk("dp_key", bus.dp_key, bus.rk);
    if (bus.out_valid) chk("out_block", bus.out_block, exp_ct);
    if (bus.in_valid && bus.in_ready && !bus.abort) seq = 0;
    else if (!bus.abort && bus.rk_req && bus.rk_valid) begin
      chk("rk_idx_seq", bus.rk_idx, seq);
      seq++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_rk_req"}, bus.rk_req, 0);
    chk({tag, "_rk_idx"}, bus.rk_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_dp_final"}, bus.dp_final, 0);
    chk({tag, "_out_block"}, bus.out_block, 0);
  endtask

  task automatic start_block(input logic [127:0] pt);
    int n = 0;
    while (!bus.in_ready && n < 100) begin step(); n++; end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_block = pt;
    exp_ct       = aes_enc(pt);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input int exp_edges, input int hold);
    int n = 0;
    logic [127:0] ob;
    start_block(pt);
    do begin step(); n++; end while (!bus.out_valid && n < 300);
    chk("latency_edges", n, exp_edges);
    chk("result", bus.out_block, exp_ct);
    ob = bus.out_block;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_block", bus.out_block, ob);
    end
    // A block offered during the handoff edge must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("handoff_in_ready", bus.in_ready, 1);
    chk("handoff_no_accept", bus.busy, 0);
    chk("handoff_st_kept", bus.out_block, ob);
  endtask

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] ob;
    int n;
    logic saw_valid;
    rst = 1'b1;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_block = '0; bus.out_ready = 1'b0;
    exp_ct = '0;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    #1;
    // Pin the reference model to FIPS-197 C.1.
    chk("model_rk1", rkeys[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_rk10", rkeys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_ct", aes_enc(PT1), CT1);
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: FIPS vector with rk_valid tied high
    run_block(PT1, NR + 1, 0);
    chk("vec1_literal", bus.out_block, CT1);

    // 2: three wait cycles per key request
    dly_mode = 1'b1;
    run_block(PT1, 4 * (NR + 1), 0);
    dly_mode = 1'b0;

    // 3: consumer stalls for five cycles
    run_block(PT2, NR + 1, 5);

    // 4: abort at round 5, then a clean block
    start_block(PT1);
    n = 0;
    while (bus.rk_idx != 4'd5 && n < 50) begin step(); n++; end
    chk("abort_reach_round5", bus.rk_idx, 5);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_rk_req", bus.rk_req, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); saw_valid |= bus.out_valid; end
    chk("abort_no_output", saw_valid, 0);
    run_block(PT2, NR + 1, 0);

    // 5: asynchronous reset pulse between edges, mid-ROUND
    start_block(PT2);
    repeat (4) step();
    chk("pre_rst_busy", bus.busy, 1);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    #1 rst = 1'b0;
    run_block(PT1, NR + 1, 0);
    chk("post_rst_literal", bus.out_block, CT1);

    // 6: rk_valid strobed in IDLE is ignored
    dly_mode = 1'b1;
    ob = bus.out_block;
    rk_force = 1'b1;
    step();
    step();
    rk_force = 1'b0;
    dly_mode = 1'b0;
    chk("idle_rk_in_ready", bus.in_ready, 1);
    chk("idle_rk_busy", bus.busy, 0);
    chk("idle_rk_st", bus.out_block, ob);
    chk("idle_rk_dp_final", bus.dp_final, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
